ts_os_detector: RTL and testbench
=================================

# ts_os_detector

Receive-side training ordered-set detector for one lane. It consumes 8b/10b-decoded symbols from the lane deskew/decoder stage and recognises TS1 and TS2 ordered sets. It requires CONSEC_TS consecutive identical sets before raising the `ts1_received` / `ts2_received` levels used by the link training state machine. It also publishes the link number, lane number, N_FTS, rate ID and training-control fields of the qualified set.

## Interface
- CONSEC_TS, 8, number of consecutive identical TS1 (or TS2) sets required to assert a flag; legal range 1..255.
- clk  input  1  sole clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx_valid  input  1  symbol strobe; a symbol is accepted only on cycles with rx_valid=1.
- rx_data  input  8  decoded symbol byte.
- rx_is_k  input  1  1 = control (K) symbol.
- symbol_lock  input  1  decoder symbol lock; 0 forces a synchronous clear.
- ts_clear  input  1  single-cycle pulse from training control; clears qualification.
- ts1_received  output  1  level: CONSEC_TS identical TS1 sets received.
- ts2_received  output  1  level: CONSEC_TS identical TS2 sets received.
- rx_link_num  output  8  link number of the qualified set.
- rx_link_pad  output  1  link number field was PAD.
- rx_lane_num  output  8  lane number of the qualified set.
- rx_lane_pad  output  1  lane number field was PAD.
- rx_n_fts  output  8  N_FTS field.
- rx_rate_id  output  8  data rate identifier field.
- rx_train_ctrl  output  8  training control field.
- os_error  output  1  one-cycle pulse on a malformed ordered set.

## Operation
- Set format, symbol index 0..15:
  - 0: COM (K, 0xBC).
  - 1: link number (data, or PAD = K 0xF7).
  - 2: lane number (data or PAD).
  - 3: N_FTS (data).
  - 4: rate ID (data).
  - 5: training control (data).
  - 6..15: identifier, data. 0x4A = TS1, 0x45 = TS2.
- FSM states:
  - HUNT: wait for COM; go to HDR with index=1.
  - HDR: capture symbols 1..5. A K symbol at index 1/2 is legal only if it is 0xF7. A K symbol at index 3..5 is illegal.
  - ID: at index 6, the data byte selects the type (0x4A TS1, 0x45 TS2; anything else is illegal). Index 7..15 must repeat the same byte with K=0. The symbol at index 15 completes the set and returns to HUNT.
- Illegal symbol in HDR/ID:
  - os_error pulses and the match count clears to 0.
  - Flags drop.
  - The FSM returns to HUNT, except when the offending symbol is COM: then it goes to HDR with index=1, so a new set starts on that COM.
- On set completion, compare type plus the 5 header fields (including pad bits) with the stored candidate:
  - Equal: count increments, saturating at CONSEC_TS.
  - Different: store as the new candidate and set count=1.
- Flags:
  - ts1_received = (count==CONSEC_TS && candidate type==TS1); ts2_received likewise for TS2.
  - They are never high together.
  - Output fields load from the candidate on the completion that makes count reach CONSEC_TS, and hold otherwise.
- rx_valid=0: the FSM, index and count freeze; no timeout inside this block.
- symbol_lock=0 or ts_clear=1:
  - FSM goes to HUNT, count=0, candidate invalidated, flags 0.
  - The symbol on that cycle is ignored.
  - Output fields hold.
  - ts_clear takes precedence over any simultaneous set completion.
- Count width is $clog2(CONSEC_TS+1). Count never wraps.

## Timing
- Reset values: ts1_received=0, ts2_received=0, os_error=0, all field outputs 0, pad bits 0, FSM=HUNT, count=0.
- All outputs are registered.
- A flag asserts in the cycle after the 16th symbol of the CONSEC_TS-th identical set is accepted. Field outputs update in that same cycle.
- A flag deasserts in the cycle after any of:
  - completion of a differing set (for CONSEC_TS=1, the other flag asserts in that same cycle instead);
  - an illegal symbol;
  - the symbol_lock=0 cycle;
  - the ts_clear cycle.
- os_error is high for exactly the cycle after the illegal symbol.
- Back-to-back sets with no gap between index 15 and the next COM are accepted at full rate: 16 cycles per set.
- Reset asserted mid-set aborts immediately (asynchronously) to the reset values.

## Test plan
- Flag assertion: 8 identical TS1 sets (link PAD, lane PAD, N_FTS 0x1F, rate 0x02, ctrl 0x00), rx_valid=1 continuously -> ts1_received rises 1 cycle after symbol 128, rx_link_pad=1, rx_n_fts=0x1F; ts2_received stays 0.
- Content change: 7 TS1 sets, then 1 TS1 with lane 0x03, then 7 more TS1 with lane 0x03 -> no flag until the end of the 8th lane-0x03 set; then rx_lane_num=0x03, rx_lane_pad=0.
- Type switch: 8 TS1 sets then 8 TS2 sets -> ts1_received falls 1 cycle after the 1st TS2 completes; ts2_received rises after the 8th TS2; never both high.
- Malformed set: a TS2 with identifier symbol 9 = 0x4A, followed immediately by COM -> os_error one-cycle pulse, count=0, and the following set is counted as the 1st.
- Stalls: rx_valid toggling 1/0 every cycle through 8 TS1 sets -> same result as the first scenario; flag rises 1 cycle after the 128th accepted symbol.
- Clears: flags high, then a ts_clear pulse (and separately symbol_lock=0 for 1 cycle) -> flags 0 next cycle, fields hold, 8 fresh sets are needed to re-assert. An asynchronous reset mid-set -> all outputs 0 immediately.

Source files
------------

// File: rtl/ts_os_detector_if.sv
// rtl/ts_os_detector_if.sv - symbol stream, training control and qualified-set outputs of one lane
interface ts_os_detector_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_is_k;
  logic       symbol_lock;
  logic       ts_clear;
  logic       ts1_received;
  logic       ts2_received;
  logic [7:0] rx_link_num;
  logic       rx_link_pad;
  logic [7:0] rx_lane_num;
  logic       rx_lane_pad;
  logic [7:0] rx_n_fts;
  logic [7:0] rx_rate_id;
  logic [7:0] rx_train_ctrl;
  logic       os_error;

  modport master (
    output rx_valid, rx_data, rx_is_k, symbol_lock, ts_clear,
    input  ts1_received, ts2_received, rx_link_num, rx_link_pad, rx_lane_num,
           rx_lane_pad, rx_n_fts, rx_rate_id, rx_train_ctrl, os_error
  );

  modport slave (
    input  rx_valid, rx_data, rx_is_k, symbol_lock, ts_clear,
    output ts1_received, ts2_received, rx_link_num, rx_link_pad, rx_lane_num,
           rx_lane_pad, rx_n_fts, rx_rate_id, rx_train_ctrl, os_error
  );
endinterface

// File: rtl/ts_os_detector.sv
// rtl/ts_os_detector.sv - TS1/TS2 ordered-set detector with consecutive-set qualification
module ts_os_detector #(
  parameter int CONSEC_TS = 8
) (
  input  logic             clk,
  input  logic             reset,
  ts_os_detector_if.slave  bus
);

  localparam int             CW      = $clog2(CONSEC_TS + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(CONSEC_TS);
  localparam logic [7:0]     SYM_COM = 8'hBC;
  localparam logic [7:0]     SYM_PAD = 8'hF7;
  localparam logic [7:0]     ID_TS1  = 8'h4A;
  localparam logic [7:0]     ID_TS2  = 8'h45;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    HDR  = 2'd1,
    ID   = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0] link;
    logic       link_pad;
    logic [7:0] lane;
    logic       lane_pad;
    logic [7:0] n_fts;
    logic [7:0] rate_id;
    logic [7:0] train_ctrl;
  } hdr_t;

  state_t        state, state_nxt;
  logic [3:0]    idx, idx_nxt;
  logic          clear, accept, is_com, illegal, complete;
  logic [7:0]    id_byte;

  hdr_t          cur_hdr, cand_hdr, out_hdr;
  logic          cur_type, cand_type, cand_valid;
  logic [CW-1:0] count, count_upd;
  logic          same_set, at_max;
  logic          ts1_q, ts2_q, os_error_q;

  assign clear   = !bus.symbol_lock || bus.ts_clear;
  assign accept  = bus.rx_valid && !clear;
  assign is_com  = bus.rx_is_k && (bus.rx_data == SYM_COM);
  assign id_byte = cur_type ? ID_TS2 : ID_TS1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= HUNT;
      idx   <= 4'd0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    illegal   = 1'b0;
    complete  = 1'b0;
    if (clear) begin
      state_nxt = HUNT;
      idx_nxt   = 4'd0;
    end else if (accept) begin
      case (state)
        HUNT: begin
          if (is_com) begin
            state_nxt = HDR;
            idx_nxt   = 4'd1;
          end
        end
        HDR: begin
          // Only link/lane may carry a K symbol, and then only PAD.
          if (bus.rx_is_k && (idx >= 4'd3 || bus.rx_data != SYM_PAD)) begin
            illegal = 1'b1;
          end else if (idx == 4'd5) begin
            state_nxt = ID;
            idx_nxt   = 4'd6;
          end else begin
            idx_nxt = idx + 4'd1;
          end
        end
        ID: begin
          if (bus.rx_is_k) begin
            illegal = 1'b1;
          end else if (idx == 4'd6) begin
            if (bus.rx_data != ID_TS1 && bus.rx_data != ID_TS2) illegal = 1'b1;
            else idx_nxt = 4'd7;
          end else if (bus.rx_data != id_byte) begin
            illegal = 1'b1;
          end else if (idx == 4'd15) begin
            complete  = 1'b1;
            state_nxt = HUNT;
            idx_nxt   = 4'd0;
          end else begin
            idx_nxt = idx + 4'd1;
          end
        end
        default: begin
          state_nxt = HUNT;
          idx_nxt   = 4'd0;
        end
      endcase
      // A COM that breaks a set is itself the start of the next one.
      if (illegal) begin
        state_nxt = is_com ? HDR : HUNT;
        idx_nxt   = is_com ? 4'd1 : 4'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_hdr  <= '0;
      cur_type <= 1'b0;
    end else if (accept) begin
      if (state == HDR) begin
        case (idx)
          4'd1: begin
            cur_hdr.link     <= bus.rx_data;
            cur_hdr.link_pad <= bus.rx_is_k;
          end
          4'd2: begin
            cur_hdr.lane     <= bus.rx_data;
            cur_hdr.lane_pad <= bus.rx_is_k;
          end
          4'd3:    cur_hdr.n_fts      <= bus.rx_data;
          4'd4:    cur_hdr.rate_id    <= bus.rx_data;
          4'd5:    cur_hdr.train_ctrl <= bus.rx_data;
          default: ;
        endcase
      end else if (state == ID && idx == 4'd6) begin
        cur_type <= (bus.rx_data == ID_TS2);
      end
    end
  end

  assign same_set = cand_valid && (cand_type == cur_type) && (cand_hdr == cur_hdr);

  always_comb begin
    count_upd = CW'(1);
    if (same_set) count_upd = (count == CNT_MAX) ? count : count + CW'(1);
  end

  assign at_max = (count_upd == CNT_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count      <= '0;
      cand_valid <= 1'b0;
      cand_type  <= 1'b0;
      cand_hdr   <= '0;
      out_hdr    <= '0;
      ts1_q      <= 1'b0;
      ts2_q      <= 1'b0;
      os_error_q <= 1'b0;
    end else begin
      os_error_q <= illegal;
      if (clear || illegal) begin
        count      <= '0;
        cand_valid <= 1'b0;
        ts1_q      <= 1'b0;
        ts2_q      <= 1'b0;
      end else if (complete) begin
        count      <= count_upd;
        cand_valid <= 1'b1;
        cand_type  <= cur_type;
        cand_hdr   <= cur_hdr;
        ts1_q      <= at_max && !cur_type;
        ts2_q      <= at_max && cur_type;
        // Candidate equals the completed set whether it matched or replaced.
        if (at_max) out_hdr <= cur_hdr;
      end
    end
  end

  assign bus.ts1_received  = ts1_q;
  assign bus.ts2_received  = ts2_q;
  assign bus.os_error      = os_error_q;
  assign bus.rx_link_num   = out_hdr.link;
  assign bus.rx_link_pad   = out_hdr.link_pad;
  assign bus.rx_lane_num   = out_hdr.lane;
  assign bus.rx_lane_pad   = out_hdr.lane_pad;
  assign bus.rx_n_fts      = out_hdr.n_fts;
  assign bus.rx_rate_id    = out_hdr.rate_id;
  assign bus.rx_train_ctrl = out_hdr.train_ctrl;

endmodule

// File: tb/tb_ts_os_detector.sv
// tb/tb_ts_os_detector.sv - directed scoreboard bench for ts_os_detector
module tb_ts_os_detector;

  localparam int CONSEC = 8;

  typedef struct packed {
    logic [7:0] link;
    logic       link_pad;
    logic [7:0] lane;
    logic       lane_pad;
    logic [7:0] n_fts;
    logic [7:0] rate_id;
    logic [7:0] train_ctrl;
  } hdr_t;

  typedef struct {
    int   due;
    logic ts1;
    logic ts2;
    logic os_err;
    hdr_t f;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ts_os_detector_if bus();

  ts_os_detector #(.CONSEC_TS(CONSEC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  // set-level reference model
  int   m_count = 0;
  logic m_valid = 1'b0;
  logic m_type  = 1'b0;
  hdr_t m_cand  = '0;
  hdr_t m_pub   = '0;
  logic m_ts1   = 1'b0;
  logic m_ts2   = 1'b0;

  // state last published by the scoreboard; held between events
  logic h_ts1 = 1'b0;
  logic h_ts2 = 1'b0;
  hdr_t h_f   = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic hdr_t dut_fields();
    hdr_t f;
    f.link       = bus.rx_link_num;
    f.link_pad   = bus.rx_link_pad;
    f.lane       = bus.rx_lane_num;
    f.lane_pad   = bus.rx_lane_pad;
    f.n_fts      = bus.rx_n_fts;
    f.rate_id    = bus.rx_rate_id;
    f.train_ctrl = bus.rx_train_ctrl;
    return f;
  endfunction

  task automatic push_exp(input logic os_err);
    exp_t e;
    e.due    = cyc;
    e.ts1    = m_ts1;
    e.ts2    = m_ts2;
    e.os_err = os_err;
    e.f      = m_pub;
    sb.push_back(e);
  endtask

  task automatic model_complete(input logic t2, input hdr_t h);
    if (m_valid && m_type == t2 && m_cand == h) begin
      if (m_count < CONSEC) m_count++;
    end else begin
      m_valid = 1'b1;
      m_type  = t2;
      m_cand  = h;
      m_count = 1;
    end
    if (m_count == CONSEC) m_pub = m_cand;
    m_ts1 = (m_count == CONSEC) && !m_type;
    m_ts2 = (m_count == CONSEC) && m_type;
    push_exp(1'b0);
  endtask

  task automatic model_drop(input logic os_err);
    m_count = 0;
    m_valid = 1'b0;
    m_ts1   = 1'b0;
    m_ts2   = 1'b0;
    push_exp(os_err);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      h_ts1 = 1'b0;
      h_ts2 = 1'b0;
      h_f   = '0;
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      h_ts1 = e.ts1;
      h_ts2 = e.ts2;
      h_f   = e.f;
      check("event_ts1", 64'(bus.ts1_received), 64'(e.ts1));
      check("event_ts2", 64'(bus.ts2_received), 64'(e.ts2));
      check("event_os_error", 64'(bus.os_error), 64'(e.os_err));
      check("event_fields", 64'(dut_fields()), 64'(e.f));
    end else begin
      check("hold_ts1", 64'(bus.ts1_received), 64'(h_ts1));
      check("hold_ts2", 64'(bus.ts2_received), 64'(h_ts2));
      check("hold_os_error", 64'(bus.os_error), 64'(1'b0));
      check("hold_fields", 64'(dut_fields()), 64'(h_f));
    end
    if (reset) check("flags_exclusive", 64'(bus.ts1_received && bus.ts2_received), 64'(1'b0));
  end

  task automatic drive_sym(input logic v, input logic k, input logic [7:0] d,
                           input logic clr, input logic lock);
    bus.rx_valid    = v;
    bus.rx_is_k     = k;
    bus.rx_data     = d;
    bus.ts_clear    = clr;
    bus.symbol_lock = lock;
    @(posedge clk);
    #1;
    bus.rx_valid    = 1'b0;
    bus.ts_clear    = 1'b0;
    bus.symbol_lock = 1'b1;
  endtask

  task automatic set_sym(input logic t2, input hdr_t h, input int i,
                         output logic k, output logic [7:0] d);
    k = 1'b0;
    case (i)
      0:       begin k = 1'b1; d = 8'hBC; end
      1:       begin k = h.link_pad; d = h.link; end
      2:       begin k = h.lane_pad; d = h.lane; end
      3:       d = h.n_fts;
      4:       d = h.rate_id;
      5:       d = h.train_ctrl;
      default: d = t2 ? 8'h45 : 8'h4A;
    endcase
  endtask

  task automatic send_set(input logic t2, input hdr_t h, input bit stall, input bit clr_last);
    for (int i = 0; i < 16; i++) begin
      logic       k;
      logic [7:0] d;
      set_sym(t2, h, i, k, d);
      if (i == 15 && clr_last) begin
        drive_sym(1'b1, k, d, 1'b1, 1'b1);
        model_drop(1'b0);
      end else begin
        drive_sym(1'b1, k, d, 1'b0, 1'b1);
        if (i == 15) model_complete(t2, h);
      end
      if (stall) drive_sym(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    end
  endtask

  task automatic send_sets(input int n, input logic t2, input hdr_t h, input bit stall);
    for (int s = 0; s < n; s++) send_set(t2, h, stall, 1'b0);
  endtask

  hdr_t h_pad, h_l3;

  initial begin
    h_pad = '0;
    h_pad.link = 8'hF7; h_pad.link_pad = 1'b1;
    h_pad.lane = 8'hF7; h_pad.lane_pad = 1'b1;
    h_pad.n_fts = 8'h1F; h_pad.rate_id = 8'h02; h_pad.train_ctrl = 8'h00;
    h_l3 = h_pad;
    h_l3.lane = 8'h03; h_l3.lane_pad = 1'b0;

    bus.rx_valid = 1'b0; bus.rx_is_k = 1'b0; bus.rx_data = 8'h00;
    bus.ts_clear = 1'b0; bus.symbol_lock = 1'b1;

    // reset values
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ts1", 64'(bus.ts1_received), 64'(1'b0));
    check("rst_ts2", 64'(bus.ts2_received), 64'(1'b0));
    check("rst_os_error", 64'(bus.os_error), 64'(1'b0));
    check("rst_fields", 64'(dut_fields()), 64'(0));
    reset = 1'b1;
    @(posedge clk); #1;

    // eight identical TS1 sets qualify
    send_sets(CONSEC, 1'b0, h_pad, 1'b0);
    check("s1_ts1", 64'(bus.ts1_received), 64'(1'b1));
    check("s1_link_pad", 64'(bus.rx_link_pad), 64'(1'b1));
    check("s1_n_fts", 64'(bus.rx_n_fts), 64'(8'h1F));

    // ts_clear drops the flag; fields hold
    drive_sym(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    model_drop(1'b0);
    check("clr_ts1", 64'(bus.ts1_received), 64'(1'b0));
    check("clr_n_fts_hold", 64'(bus.rx_n_fts), 64'(8'h1F));

    // content change: 7 pad sets, then 8 lane-3 sets
    send_sets(CONSEC - 1, 1'b0, h_pad, 1'b0);
    check("s2_no_flag", 64'(bus.ts1_received), 64'(1'b0));
    send_sets(CONSEC, 1'b0, h_l3, 1'b0);
    check("s2_lane", 64'(bus.rx_lane_num), 64'(8'h03));
    check("s2_lane_pad", 64'(bus.rx_lane_pad), 64'(1'b0));

    // type switch
    send_sets(CONSEC, 1'b1, h_l3, 1'b0);
    check("s3_ts2", 64'(bus.ts2_received), 64'(1'b1));

    // malformed TS2 (symbol 9 = 0x4A), followed immediately by a COM
    for (int i = 0; i < 10; i++) begin
      logic       k;
      logic [7:0] d;
      set_sym(1'b1, h_l3, i, k, d);
      if (i == 9) d = 8'h4A;
      drive_sym(1'b1, k, d, 1'b0, 1'b1);
    end
    model_drop(1'b1);
    send_sets(CONSEC - 1, 1'b1, h_l3, 1'b0);
    check("s4_not_yet", 64'(bus.ts2_received), 64'(1'b0));
    send_set(1'b1, h_l3, 1'b0, 1'b0);
    check("s4_ts2", 64'(bus.ts2_received), 64'(1'b1));

    // one cycle of lost symbol lock
    drive_sym(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    model_drop(1'b0);

    // rx_valid toggling every cycle
    send_sets(CONSEC, 1'b0, h_pad, 1'b1);
    check("s5_ts1", 64'(bus.ts1_received), 64'(1'b1));

    // ts_clear coincident with a set completion wins
    send_set(1'b0, h_pad, 1'b0, 1'b1);
    check("s6_clear_wins", 64'(bus.ts1_received), 64'(1'b0));

    // asynchronous reset mid-set
    send_sets(CONSEC, 1'b0, h_pad, 1'b0);
    for (int i = 0; i < 5; i++) begin
      logic       k;
      logic [7:0] d;
      set_sym(1'b0, h_pad, i, k, d);
      drive_sym(1'b1, k, d, 1'b0, 1'b1);
    end
    #1 reset = 1'b0;
    #1;
    check("arst_ts1", 64'(bus.ts1_received), 64'(1'b0));
    check("arst_fields", 64'(dut_fields()), 64'(0));
    m_count = 0; m_valid = 1'b0; m_ts1 = 1'b0; m_ts2 = 1'b0; m_pub = '0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    send_set(1'b0, h_pad, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drain", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
